fp_tamsayi_cevirici: RTL and testbench

Converts an IEEE-754 single-precision operand to a 32-bit signed or unsigned integer (RV32F FCVT.W.S / FCVT.WU.S), with all five RISC-V rounding modes and NV/NX exception flags. It is the float-to-integer counterpart of the integer-to-float path. That path normalises with the 28-bit leading-one detector; this block instead denormalises with an exponent-driven right shift. It sits in the FPU execute stage behind the operand mux and is a two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_tamsayi_cevirici_pkg.sv | 17 +
 rtl/fp_tamsayi_cevirici_saga_kaydir_yapiskan.sv | 14 +
 rtl/fp_tamsayi_cevirici.sv | 97 +++++++++
 tb/tb_fp_tamsayi_cevirici.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_tamsayi_cevirici_pkg.sv
// fp_tamsayi_cevirici_pkg: shared FPU rounding modes, flag indices and integer limits
package fp_tamsayi_cevirici_pkg;
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/fp_tamsayi_cevirici_saga_kaydir_yapiskan.sv
// saga_kaydir_yapiskan: right-shifts a significand, keeping integer part, round bit and sticky
module saga_kaydir_yapiskan (
  input  logic [23:0] sig,
  input  logic [4:0]  sh,
  output logic [31:0] tam,
  output logic        r,
  output logic        s
);
  logic [49:0] wide;
  assign wide = {sig, 26'b0} >> sh;
  assign tam = {8'b0, wide[49:26]};
  assign r = wide[25];
  assign s = |wide[24:0];
endmodule

// File: rtl/fp_tamsayi_cevirici.sv
// fp_tamsayi_cevirici: two-stage single-precision to 32-bit int/uint converter (FCVT.W[U].S)
module fp_tamsayi_cevirici
  import fp_tamsayi_cevirici_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op,
  input  logic [2:0]  in_rm,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic s1_sign, s1_nan, s1_inf, s1_large, s1_uns;
  logic [23:0] s1_sig;
  logic [2:0] s1_rm;
  logic signed [9:0] s1_exp, e_in, rsh;
  logic [4:0] sh, lsh;
  logic [31:0] shifted, tam, res;
  logic [32:0] rnd;
  logic r_raw, s_raw, r, st, left, inc, big, pos_ovf, neg_ovf, uns_neg, nv, nx;
  logic [4:0] flg;
  assign s2_adv = ~s2_valid | out_ready;
  assign s1_adv = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;
  assign e_in = $signed({2'b00, in_op[30:23]} - 10'(EXP_BIAS));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp <= '0;
      s1_sig <= '0;
      s1_nan <= 1'b0;
      s1_inf <= 1'b0;
      s1_large <= 1'b0;
      s1_rm <= '0;
      s1_uns <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_sign <= in_op[31];
      s1_exp <= e_in;
      s1_sig <= {|in_op[30:23], in_op[22:0]};
      s1_nan <= (&in_op[30:23]) & (|in_op[22:0]);
      s1_inf <= (&in_op[30:23]) & ~(|in_op[22:0]);
      s1_large <= e_in >= 10'sd32;
      s1_rm <= in_rm;
      s1_uns <= in_unsigned;
    end
  end
  // Exponents >= 23 shift left losslessly; smaller ones denormalise right, clamped so all bits land in sticky
  assign left = s1_exp >= 10'sd23;
  assign rsh = 10'sd23 - s1_exp;
  assign sh = rsh > 10'sd26 ? 5'd26 : rsh[4:0];
  assign lsh = s1_exp[4:0] - 5'd23;
  saga_kaydir_yapiskan u_kaydir (.sig(s1_sig), .sh(sh), .tam(shifted), .r(r_raw), .s(s_raw));
  assign tam = left ? {8'b0, s1_sig} << lsh : shifted;
  assign r = ~left & r_raw;
  assign st = ~left & s_raw;
  assign inc = s1_rm == RM_RNE ? r & (st | tam[0]) :
               s1_rm == RM_RDN ? s1_sign & (r | st) :
               s1_rm == RM_RUP ? ~s1_sign & (r | st) :
               s1_rm == RM_RMM ? r : 1'b0;
  assign rnd = {1'b0, tam} + {32'b0, inc};
  assign big = s1_inf | s1_large;
  assign pos_ovf = ~s1_sign & (big | rnd > (s1_uns ? {1'b0, UINT_MAX} : {1'b0, INT_MAX}));
  assign neg_ovf = s1_sign & ~s1_uns & (big | rnd > {1'b0, INT_MIN});
  assign uns_neg = s1_sign & s1_uns & (big | rnd != 33'd0);
  assign nv = s1_nan | pos_ovf | neg_ovf | uns_neg;
  assign nx = (r | st) & ~nv;
  assign res = (s1_nan | pos_ovf) ? (s1_uns ? UINT_MAX : INT_MAX) :
               neg_ovf ? INT_MIN :
               uns_neg ? 32'd0 :
               s1_sign ? -rnd[31:0] : rnd[31:0];
  always_comb begin
    flg = '0;
    flg[FLG_NV] = nv;
    flg[FLG_NX] = nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_result <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_flags <= flg;
      end
    end
  end
endmodule

// File: tb/tb_fp_tamsayi_cevirici.sv
// tb_fp_tamsayi_cevirici: directed, backpressure, reset and random checks against an arithmetic model
module tb_fp_tamsayi_cevirici;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_unsigned = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [31:0] in_op = '0, out_result;
  logic [2:0] in_rm = '0;
  logic [4:0] out_flags;
  int n_chk = 0, n_pass = 0;
  logic [36:0] q[$];
  logic [36:0] cur_exp = '0, held = '0;
  logic acc = 1'b0, stall_prev = 1'b0, rnd_done = 1'b0;

  typedef struct packed {
    logic [31:0] op;
    logic [2:0]  rm;
    logic        uns;
    logic [36:0] exp;
  } vec_t;

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] NX = 5'b00001;

  vec_t dv [17] = '{
    '{32'h3FC00000, 3'd0, 1'b0, {NX, 32'd2}},
    '{32'h3FC00000, 3'd1, 1'b0, {NX, 32'd1}},
    '{32'h3FC00000, 3'd2, 1'b0, {NX, 32'd1}},
    '{32'h3FC00000, 3'd3, 1'b0, {NX, 32'd2}},
    '{32'h40200000, 3'd0, 1'b0, {NX, 32'd2}},
    '{32'h40200000, 3'd4, 1'b0, {NX, 32'd3}},
    '{32'hC0200000, 3'd2, 1'b0, {NX, 32'hFFFFFFFD}},
    '{32'h4F000000, 3'd1, 1'b0, {NV, 32'h7FFFFFFF}},
    '{32'h4F000000, 3'd1, 1'b1, {5'b0, 32'h80000000}},
    '{32'hCF000000, 3'd1, 1'b0, {5'b0, 32'h80000000}},
    '{32'hBF800000, 3'd0, 1'b1, {NV, 32'd0}},
    '{32'hBF000000, 3'd1, 1'b1, {NX, 32'd0}},
    '{32'h7FC00000, 3'd0, 1'b0, {NV, 32'h7FFFFFFF}},
    '{32'h7FC00000, 3'd0, 1'b1, {NV, 32'hFFFFFFFF}},
    '{32'hFF800000, 3'd0, 1'b0, {NV, 32'h80000000}},
    '{32'h00000000, 3'd0, 1'b0, {5'b0, 32'd0}},
    '{32'h80000000, 3'd3, 1'b1, {5'b0, 32'd0}}
  };

  always #5 clk = ~clk;

  fp_tamsayi_cevirici dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rm(in_rm), .in_unsigned(in_unsigned), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Exact real-number semantics: value = sig * 2^(e-23), rounded by mode, then range-checked
  function automatic logic [36:0] model(input logic [31:0] op, input logic [2:0] rm, input logic uns);
    logic s;
    int e_b, k;
    longint sig, mag, rem, half, v;
    logic up;
    s = op[31];
    e_b = int'(op[30:23]);
    if (e_b == 255 && op[22:0] != 0) return {NV, uns ? 32'hFFFFFFFF : 32'h7FFFFFFF};
    sig = longint'(op[22:0]);
    if (e_b != 0) sig += 64'sd1 << 23;
    k = 23 - (e_b - 127);
    rem = 0;
    half = 1;
    if (e_b == 255) mag = 64'sd1 << 40;
    else if (k <= 0) mag = (k < -20) ? (64'sd1 << 40) : (sig << (-k));
    else if (k > 40) begin mag = 0; rem = sig; half = 64'sd1 << 62; end
    else begin mag = sig >>> k; rem = sig & ((64'sd1 << k) - 1); half = 64'sd1 << (k - 1); end
    case (rm)
      3'd0: up = (rem > half) || (rem == half && mag[0]);
      3'd2: up = s && rem != 0;
      3'd3: up = !s && rem != 0;
      3'd4: up = rem != 0 && rem >= half;
      default: up = 1'b0;
    endcase
    mag += longint'(up);
    v = s ? -mag : mag;
    if (uns) begin
      if (v < 0) return {NV, 32'd0};
      if (v > 64'sd4294967295) return {NV, 32'hFFFFFFFF};
    end else begin
      if (v > 64'sd2147483647) return {NV, 32'h7FFFFFFF};
      if (v < -64'sd2147483648) return {NV, 32'h80000000};
    end
    return {4'b0, rem != 0, v[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 9))
      0: return $urandom;
      1: return {f[31], 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : f[22:0]};
      2: return {f[31], 8'(($urandom_range(127, 150))), f[22:0] & 23'h7F0000};
      3: return {f[31], 8'(($urandom_range(155, 160))), f[22:0]};
      default: return {f[31], 8'(($urandom_range(100, 162))), f[22:0]};
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        acc = 1'b0;
        stall_prev = 1'b0;
      end else begin
        acc = in_valid & in_ready;
        if (acc) q.push_back(cur_exp);
        if (stall_prev) chk("hold", {out_flags, out_result}, held);
        if (out_valid & out_ready) begin
          if (q.size() == 0) chk("expected_pending", 37'(q.size()), 37'd1);
          else chk("result", {out_flags, out_result}, q.pop_front());
        end
        stall_prev = out_valid & ~out_ready;
        held = {out_flags, out_result};
      end
    end
  end

  task automatic send(input logic [31:0] op, input logic [2:0] rm, input logic uns, input logic [36:0] exp);
    in_op = op;
    in_rm = rm;
    in_unsigned = uns;
    cur_exp = exp;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 37'(acc), 37'd1);
  endtask

  task automatic send_model(input logic [31:0] op, input logic [2:0] rm, input logic uns);
    send(op, rm, uns, model(op, rm, uns));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 37'(q.size()), 37'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 37'(out_valid), 37'd0);
    chk("reset_out", {out_flags, out_result}, 37'd0);
    rst_n = 1'b1;
    chk("ready_after_reset", 37'(in_ready), 37'd1);
    foreach (dv[i]) send(dv[i].op, dv[i].rm, dv[i].uns, dv[i].exp);
    drain();
    fork
      begin
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          if (c == 5) chk("bp_in_ready", 37'(in_ready), 37'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        send_model(32'h3FC00000, 3'd0, 1'b0);
        send_model(32'h40200000, 3'd4, 1'b0);
        send_model(32'hC0200000, 3'd2, 1'b0);
        send_model(32'h4B3FFFFF, 3'd3, 1'b1);
        send_model(32'h3F000000, 3'd0, 1'b0);
      end
    join
    drain();
    send_model(32'h40400000, 3'd0, 1'b0);
    send_model(32'hC1200000, 3'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_flush_valid", 37'(out_valid), 37'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_reset_idle", 37'(out_valid), 37'd0);
    end
    send(32'h3FC00000, 3'd0, 1'b0, {NX, 32'd2});
    chk("latency_not_early", 37'(out_valid), 37'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 37'(out_valid), 37'd1);
    chk("latency_result", {out_flags, out_result}, {NX, 32'd2});
    drain();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_model(rand_op(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = $urandom_range(0, 3) != 0;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
